// File: rtl/logic_gates_pkg.sv
// Shared definitions for the logic_gates response checker: gate bit
// positions, FSM state encodings and the golden gate function.
package logic_gates_pkg;

  localparam int NUM_GATES = 7;

  // Bit positions of each gate inside every 7-bit output/mismatch vector.
  localparam int GATE_AND  = 0;
  localparam int GATE_OR   = 1;
  localparam int GATE_NAND = 2;
  localparam int GATE_NOR  = 3;
  localparam int GATE_NOTB = 4;
  localparam int GATE_XOR  = 5;
  localparam int GATE_XNOR = 6;

  // Run-control FSM encodings.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Expected gate outputs for one (a,b) stimulus.
  function automatic logic [NUM_GATES-1:0] gates_expected(input logic a, input logic b);
    logic [NUM_GATES-1:0] e;
    e            = '0;
    e[GATE_AND]  = a & b;
    e[GATE_OR]   = a | b;
    e[GATE_NAND] = ~(a & b);
    e[GATE_NOR]  = ~(a | b);
    e[GATE_NOTB] = ~b;
    e[GATE_XOR]  = a ^ b;
    e[GATE_XNOR] = ~(a ^ b);
    return e;
  endfunction

endpackage

// File: rtl/logic_gates_ref.sv
// Combinational golden model of the two-input logic_gates block.
module logic_gates_ref
  import logic_gates_pkg::*;
(
  input  logic                 a,
  input  logic                 b,
  output logic [NUM_GATES-1:0] expected
);

  assign expected = gates_expected(a, b);

endmodule

// File: rtl/logic_gates_checker.sv
// Response monitor for logic_gates: registers each accepted sample, compares
// it one cycle later against the golden model, and accumulates vector,
// error, first-failure and input-coverage statistics for a run.
module logic_gates_checker
  import logic_gates_pkg::*;
#(
  parameter int NUM_VECTORS = 4,
  parameter int CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic                 a,
  input  logic                 b,
  input  logic                 and_out,
  input  logic                 or_out,
  input  logic                 nand_out,
  input  logic                 nor_out,
  input  logic                 notb_out,
  input  logic                 xor_out,
  input  logic                 xnor_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CNT_W-1:0]     err_count,
  output logic [CNT_W-1:0]     vec_count,
  output logic [CNT_W-1:0]     first_fail_idx,
  output logic [NUM_GATES-1:0] first_fail_mask,
  output logic [3:0]           coverage
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W:0]   NUM_VEC  = (CNT_W+1)'(NUM_VECTORS);
  localparam logic [CNT_W:0]   LAST_IDX = (CNT_W+1)'(NUM_VECTORS - 1);

  logic [1:0]           state;
  logic [NUM_GATES-1:0] obs;
  logic [NUM_GATES-1:0] exp_vec;
  logic [NUM_GATES-1:0] mismatch;

  // Stage 0: registered sample awaiting comparison.
  logic                 s0_valid;
  logic                 s0_last;
  logic                 s0_a;
  logic                 s0_b;
  logic [NUM_GATES-1:0] s0_obs;
  logic [CNT_W-1:0]     s0_idx;

  logic run_start;
  logic accept;
  logic retire;

  // Gather the DUT outputs into one vector in mask bit order.
  always_comb begin
    obs            = '0;
    obs[GATE_AND]  = and_out;
    obs[GATE_OR]   = or_out;
    obs[GATE_NAND] = nand_out;
    obs[GATE_NOR]  = nor_out;
    obs[GATE_NOTB] = notb_out;
    obs[GATE_XOR]  = xor_out;
    obs[GATE_XNOR] = xnor_out;
  end

  assign run_start = start && (state != ST_RUN);
  assign accept    = (state == ST_RUN) && in_valid && ({1'b0, vec_count} < NUM_VEC);
  assign retire    = (state == ST_RUN) && s0_valid;

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);
  assign pass = done && (err_count == '0) && (coverage == 4'hF);

  // Run-control FSM: IDLE/DONE wait for start, RUN ends when the last vector retires.
  always_ff @(posedge clk) begin
    // NOTE: every clocked assignment is non-blocking so all registers see pre-edge values.
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: if (start) state <= ST_RUN;
        ST_RUN:           if (retire && s0_last) state <= ST_DONE;
        default:          state <= ST_IDLE;
      endcase
    end
  end

  // Stage 0 valid flag: one entry per accepted sample.
  always_ff @(posedge clk) begin
    if (rst) s0_valid <= 1'b0;
    else     s0_valid <= accept;
  end

  // Stage 0 payload capture.
  always_ff @(posedge clk) begin
    // NOTE: payload registers carry no reset; s0_valid alone qualifies them.
    if (accept) begin
      s0_a    <= a;
      s0_b    <= b;
      s0_obs  <= obs;
      s0_idx  <= vec_count;
      s0_last <= ({1'b0, vec_count} == LAST_IDX);
    end
  end

  logic_gates_ref u_ref (
    .a        (s0_a),
    .b        (s0_b),
    .expected (exp_vec)
  );

  // Stage 1 compare; an unknown observed bit falls to the else branch and counts as a mismatch.
  always_comb begin
    // NOTE: default first so every path assigns mismatch and no latch is inferred.
    mismatch = '0;
    for (int i = 0; i < NUM_GATES; i++) begin
      if (s0_obs[i] == exp_vec[i]) mismatch[i] = 1'b0;
      else                         mismatch[i] = 1'b1;
    end
  end

  // Run statistics: cleared on reset or run start, updated by accept and retire.
  always_ff @(posedge clk) begin
    if (rst || run_start) begin
      vec_count       <= '0;
      err_count       <= '0;
      first_fail_idx  <= '0;
      first_fail_mask <= '0;
      coverage        <= '0;
    end else begin
      if (accept && (vec_count != CNT_MAX)) vec_count <= vec_count + 1'b1;
      if (retire) begin
        coverage[{s0_a, s0_b}] <= 1'b1;
        if (|mismatch) begin
          if (err_count == '0) begin
            first_fail_idx  <= s0_idx;
            first_fail_mask <= mismatch;
          end
          if (err_count != CNT_MAX) err_count <= err_count + 1'b1;
        end
      end
    end
  end

endmodule
